// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: single-outstanding I-cache fetch with {pc, inst, exc} buffer toward decode; ports: clk/rst, pc_* from PC reg, stall_o back, flush_i, icache_* request/response, ib_* buffer head to decode
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] NOP_INST = 32'h03400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic [1:0]        pc_exc_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              icache_req_o,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic              icache_ready_i,
  input  logic              icache_rvalid_i,
  input  logic [ADDR_W-1:0] icache_rdata_i,
  output logic              ib_valid_o,
  output logic [ADDR_W-1:0] ib_pc_o,
  output logic [ADDR_W-1:0] ib_inst_o,
  output logic [1:0]        ib_exc_o,
  input  logic              ib_ready_i
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] inst_mem [FIFO_DEPTH];
  logic [1:0] exc_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0] count_q;
  logic [ADDR_W-1:0] req_pc_q, push_pc, push_inst;
  logic [1:0] push_exc;
  logic full, fetch_ok, req, stall, push, pop;
  always_comb begin
    full = count_q == (PW+1)'(FIFO_DEPTH);
    fetch_ok = pc_valid_i & ~flush_i & ~full;
    req = 1'b0;
    stall = pc_valid_i & ~flush_i;
    push = 1'b0;
    push_pc = req_pc_q;
    push_inst = icache_rdata_i;
    push_exc = 2'b00;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        req = fetch_ok & ~|pc_exc_i;
        stall = (req & ~icache_ready_i) | (pc_valid_i & ~flush_i & full);
        push = fetch_ok & |pc_exc_i;
        push_pc = pc_i;
        push_inst = NOP_INST;
        push_exc = pc_exc_i;
        state_d = req & icache_ready_i ? WAIT : IDLE;
      end
      WAIT: begin
        push = icache_rvalid_i & ~flush_i;
        state_d = icache_rvalid_i ? IDLE : flush_i ? DROP : WAIT;
      end
      DROP: state_d = icache_rvalid_i ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
    pop = (count_q != '0) & ib_ready_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (req & icache_ready_i) req_pc_q <= pc_i;
      if (flush_i) begin
        count_q <= '0;
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && push) begin
      pc_mem[wr_ptr_q] <= push_pc;
      inst_mem[wr_ptr_q] <= push_inst;
      exc_mem[wr_ptr_q] <= push_exc;
    end
  end
  assign stall_o = ~rst & stall;
  assign icache_req_o = ~rst & req;
  assign icache_addr_o = (~rst & req) ? pc_i : '0;
  assign ib_valid_o = ~rst & (count_q != '0);
  assign ib_pc_o = rst ? '0 : pc_mem[rd_ptr_q];
  assign ib_inst_o = rst ? '0 : inst_mem[rd_ptr_q];
  assign ib_exc_o = rst ? '0 : exc_mem[rd_ptr_q];
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: randomized bench for inst_fetch_ctrl against a queue-based reference model
module tb_inst_fetch_ctrl;
  localparam int D = 4;
  localparam logic [31:0] NOP = 32'h03400000;
  logic clk = 0, rst = 1;
  logic [31:0] pc = 0, rd = 0;
  logic pv = 0, fl = 0, rdy = 0, rv = 0, ibr = 0;
  logic [1:0] exc = 0;
  logic stall, req, ibv;
  logic [31:0] addr, ibpc, ibinst;
  logic [1:0] ibexc;
  inst_fetch_ctrl #(.ADDR_W(32), .FIFO_DEPTH(D), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_valid_i(pv), .pc_exc_i(exc), .stall_o(stall),
    .flush_i(fl), .icache_req_o(req), .icache_addr_o(addr), .icache_ready_i(rdy),
    .icache_rvalid_i(rv), .icache_rdata_i(rd), .ib_valid_o(ibv), .ib_pc_o(ibpc),
    .ib_inst_o(ibinst), .ib_exc_o(ibexc), .ib_ready_i(ibr));
  always #5 clk = ~clk;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic [1:0] exc;} ent_t;
  ent_t q[$];
  bit m_out = 0, m_doom = 0, last_stall = 0;
  logic [31:0] m_rpc = 0;
  logic e_req, e_stall, e_valid;
  logic [31:0] e_addr;
  ent_t e_head;
  int vectors = 0, miscompares = 0;
  function void chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  function void model_comb();
    bit full;
    full = q.size() == D;
    if (rst) begin
      e_req = 0; e_stall = 0; e_valid = 0; e_addr = 0; e_head = '0;
    end else begin
      if (!m_out) begin
        e_req = pv && !fl && !full && exc == 0;
        e_stall = (e_req && !rdy) || (pv && !fl && full);
      end else begin
        e_req = 0;
        e_stall = pv && !fl;
      end
      e_addr = e_req ? pc : 0;
      e_valid = q.size() != 0;
      e_head = e_valid ? q[0] : '0;
    end
  endfunction
  always @(posedge clk) begin
    bit full, do_pop, do_push;
    ent_t ne;
    model_comb();
    last_stall = e_stall;
    full = q.size() == D;
    do_push = 0;
    ne = '0;
    if (rst) begin
      q.delete(); m_out = 0; m_doom = 0;
    end else if (fl) begin
      q.delete();
      if (m_out) begin
        if (rv) m_out = 0;
        else m_doom = 1;
      end
    end else begin
      do_pop = q.size() != 0 && ibr;
      if (!m_out) begin
        if (pv && !full && exc != 0) begin do_push = 1; ne = '{pc, NOP, exc}; end
        if (e_req && rdy) begin m_out = 1; m_doom = 0; m_rpc = pc; end
      end else if (rv) begin
        m_out = 0;
        if (!m_doom) begin do_push = 1; ne = '{m_rpc, rd, 2'b00}; end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(ne);
    end
  end
  always begin
    @(negedge clk);
    #2;
    model_comb();
    chk("stall", stall, e_stall);
    chk("req", req, e_req);
    chk("ib_valid", ibv, e_valid);
    if (rst || e_req) chk("addr", addr, e_addr);
    if (rst || e_valid) begin
      chk("ib_pc", ibpc, e_head.pc);
      chk("ib_inst", ibinst, e_head.inst);
      chk("ib_exc", ibexc, e_head.exc);
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 0; pc = 32'h100; pv = 1; rdy = 1;
    #2 chk("t1_req", req, 1); chk("t1_addr", addr, 32'h100); chk("t1_stall", stall, 0);
    @(negedge clk); pv = 0; rdy = 0; rv = 1; rd = 32'h02801c04;
    @(negedge clk); rv = 0;
    #2 chk("t1_valid", ibv, 1); chk("t1_pc", ibpc, 32'h100); chk("t1_inst", ibinst, 32'h02801c04); chk("t1_exc", ibexc, 0);
    ibr = 1;
    @(negedge clk); ibr = 0; pc = 32'h104; pv = 1; rdy = 0;
    repeat (3) begin
      #2 chk("t2_stall", stall, 1); chk("t2_addr", addr, 32'h104);
      @(negedge clk);
    end
    rdy = 1;
    #2 chk("t2_accept_stall", stall, 0);
    @(negedge clk); pv = 0; rdy = 0; rv = 1; rd = 32'h12345678;
    @(negedge clk); rv = 0; ibr = 1;
    @(negedge clk); ibr = 0; pc = 32'h102; exc = 2'b01; pv = 1;
    #2 chk("t6_req", req, 0); chk("t6_stall", stall, 0);
    @(negedge clk); pv = 0; exc = 0;
    #2 chk("t6_pc", ibpc, 32'h102); chk("t6_inst", ibinst, NOP); chk("t6_exc", ibexc, 2'b01);
    ibr = 1;
    @(negedge clk); ibr = 0; pc = 32'h108; pv = 1; rdy = 1;
    @(negedge clk); pv = 0; rdy = 0; fl = 1;
    @(negedge clk); fl = 0;
    @(negedge clk); rv = 1; rd = 32'hdeadbeef;
    @(negedge clk); rv = 0; pc = 32'h200; pv = 1;
    #2 chk("t4_empty", ibv, 0); chk("t4_req", req, 1); chk("t4_addr", addr, 32'h200);
    @(negedge clk); pv = 0; pc = 32'h300; pv = 1; rdy = 1;
    @(negedge clk); pv = 0; rdy = 0; rst = 1;
    @(negedge clk); rst = 0;
    #2 chk("rst_valid", ibv, 0); chk("rst_req", req, 0); chk("rst_stall", stall, 0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (fl || rst) begin
        pc = $urandom & 32'hfffffffc;
        pv = $urandom_range(0, 4) != 0;
        exc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else if (!(pv && last_stall)) begin
        if (pv) pc = pc + 4;
        pv = $urandom_range(0, 4) != 0;
        exc = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      end
      fl = $urandom_range(0, 11) == 0;
      rdy = $urandom_range(0, 2) != 0;
      ibr = $urandom_range(0, 99) < ((i % 1000 < 500) ? 15 : 80);
      rv = m_out && $urandom_range(0, 2) == 0;
      rd = $urandom;
      rst = $urandom_range(0, 299) == 0;
    end
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Consumer end of the PC-generation interface.
- Takes the fetch address and valid from the PC register, issues single-outstanding requests to the I-cache, and buffers returned {pc, inst, exception} entries in a FIFO toward decode.
- Drives stall back to the PC register while it cannot accept a new address.
- On redirect flush (branch or exception), discards in-flight and buffered fetches.

Parameters:
- ADDR_W, 32, address and instruction width.
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2).
- NOP_INST, 32'h03400000, instruction word inserted for excepting fetches.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc_i  in  ADDR_W  fetch address from the PC register
- pc_valid_i  in  1  fetch enable from the PC register
- pc_exc_i  in  2  {interrupt, adef} flags tagged on pc_i
- stall_o  out  1  hold PC (the PC register keeps its value when high)
- flush_i  in  1  branch_flush OR exception_flush
- icache_req_o  out  1  request valid
- icache_addr_o  out  ADDR_W  request address
- icache_ready_i  in  1  request accepted
- icache_rvalid_i  in  1  response valid (exactly one per accepted request)
- icache_rdata_i  in  ADDR_W  response instruction
- ib_valid_o  out  1  buffer head valid
- ib_pc_o  out  ADDR_W  head PC
- ib_inst_o  out  ADDR_W  head instruction
- ib_exc_o  out  2  head exception flags
- ib_ready_i  in  1  decode pops the head when valid & ready

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, FIFO count=0, pointers=0.
- While rst is asserted, all outputs are 0: stall_o, icache_req_o, icache_addr_o, and all ib_* outputs.
- State machine (IDLE, WAIT, DROP):
  - IDLE:
    - fetch_ok = pc_valid_i & ~flush_i & (count < FIFO_DEPTH).
    - If fetch_ok & |pc_exc_i: no cache access. Push {pc_i, NOP_INST, pc_exc_i} at the clock edge; stall_o=0; stay IDLE.
    - If fetch_ok & pc_exc_i==0: icache_req_o=1, icache_addr_o=pc_i.
      - On icache_ready_i: latch pc_i into req_pc, stall_o=0, go to WAIT.
      - Otherwise stall_o=1 and the request is held combinationally (the PC is frozen, so the address is stable).
    - If pc_valid_i & ~flush_i & FIFO full: icache_req_o=0, stall_o=1.
  - WAIT:
    - icache_req_o=0; stall_o=pc_valid_i & ~flush_i.
    - icache_rvalid_i & ~flush_i: push {req_pc, icache_rdata_i, 2'b00}, go to IDLE.
    - flush_i & icache_rvalid_i in the same cycle: discard the response, go to IDLE.
    - flush_i & ~icache_rvalid_i: go to DROP.
  - DROP:
    - icache_req_o=0; stall_o=pc_valid_i & ~flush_i.
    - On icache_rvalid_i: discard, go to IDLE. A further flush_i in DROP does not change state.
- stall_o is 0 whenever flush_i=1; the PC register gives redirect priority.
- FIFO:
  - ib_valid_o = (count != 0); ib_* is driven from the head entry.
  - Pop when ib_valid_o & ib_ready_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Space is checked at request time. Only one fetch is outstanding, so a push never overflows.
  - Pointers wrap modulo FIFO_DEPTH.
- Flush:
  - At the edge with flush_i=1: count=0 and rd_ptr=wr_ptr; any push or pop in that cycle is cancelled.
  - ib_valid_o=0 from the next cycle.
- Latency:
  - Response in cycle N → ib_valid_o in N+1, when the FIFO was empty.
  - Excepting fetch in cycle N → ib_valid_o in N+1.
- Throughput: at most one cache fetch per 2 cycles (IDLE, WAIT); excepting fetches are one per cycle.
- Assertion: icache_rvalid_i in IDLE is a protocol error and is ignored.

Test Plan:
1. Basic fetch:
   - Stimulus: after reset, pc_i=0x100 valid; ready=1 in cycle 1; rvalid with rdata=0x02801c04 in cycle 2.
   - Required: cycle 1 req=1, addr=0x100, stall_o=0; cycle 3 ib_valid_o=1, pc=0x100, inst=0x02801c04, exc=0.
2. Cache backpressure:
   - Stimulus: ready=0 for 3 cycles, then 1.
   - Required: stall_o=1 and addr=0x104 stable for those 3 cycles; stall_o=0 in the accept cycle.
3. Full buffer:
   - Stimulus: ib_ready_i=0; fetch 0x100, 0x104, 0x108, 0x10c.
   - Required: count=4; fetch 0x110 is not requested and stall_o=1.
   - Stimulus: one pop.
   - Required: request for 0x110 issues the next cycle; pop order is 0x100..0x10c.
4. Flush in WAIT before response:
   - Stimulus: flush_i in WAIT; response rdata=0xdeadbeef arrives 2 cycles later.
   - Required: FSM in DROP; response discarded; buffer empty; next request uses the new pc_i=0x200.
5. Same-cycle events:
   - Stimulus: flush_i with rvalid and a pop pending.
   - Required: nothing pushed; count=0; FSM in IDLE the next cycle.
6. Excepting fetches and reset:
   - Stimulus: pc_i=0x102 with exc=2'b01.
   - Required: no icache_req_o; entry {0x102, 0x03400000, 01} visible the next cycle.
   - Stimulus: rst asserted while in WAIT.
   - Required: IDLE, count=0; all outputs 0 the next cycle.
